// File: rtl/multi_lap_stopwatch.sv
// multi_lap_stopwatch
//   Stopwatch core. It counts BCD time on an external 100 Hz tick and keeps a
//   circular memory of the last LAP_DEPTH lap times. A captured split stays
//   frozen on the display for HOLD_TICKS ticks. Stored laps can be recalled
//   one by one while the watch is stopped.
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   tick           1-cycle count enable (centisecond)
//   btn_start      start / pause pulse
//   btn_lap        lap (RUN) or clear (IDLE/PAUSE) pulse
//   btn_view       lap recall pulse (IDLE/PAUSE only)
//   disp_bcd       displayed time, digit 0 (1/100 s) in [3:0], registered
//   lap_count      stored laps, saturates at LAP_DEPTH
//   view_idx       recall index, 0 = most recent lap
//   viewing        display shows a recalled lap
//   holding        display shows a frozen split
//   running        FSM is in RUN
//   overflow       sticky: the count wrapped past all-digits-max

// One BCD digit of the ripple counter: increments on cin and carries out at max.
module msw_bcd_digit #(
  parameter int unsigned RADIX = 10
) (
  input  logic [3:0] d,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);
  localparam logic [3:0] DMAX = 4'(RADIX - 1);

  assign cout = cin & (d == DMAX);
  assign q    = !cin ? d : ((d == DMAX) ? 4'd0 : d + 4'd1);
endmodule

module multi_lap_stopwatch #(
  parameter  int unsigned NUM_DIGITS = 4,
  parameter  int unsigned LAP_DEPTH  = 4,
  parameter  int unsigned HOLD_TICKS = 200,
  localparam int unsigned IDX_W      = $clog2(LAP_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    btn_start,
  input  logic                    btn_lap,
  input  logic                    btn_view,
  output logic [4*NUM_DIGITS-1:0] disp_bcd,
  output logic [IDX_W:0]          lap_count,
  output logic [IDX_W-1:0]        view_idx,
  output logic                    viewing,
  output logic                    holding,
  output logic                    running,
  output logic                    overflow
);
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W:0]    CNT_ONE   = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0]    CNT_MAX   = (IDX_W + 1)'(LAP_DEPTH);

  typedef logic [NUM_DIGITS-1:0][3:0] bcd_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_e;

  state_e                   state_q, state_d;
  bcd_t                     time_q, time_d, time_inc;
  bcd_t [LAP_DEPTH-1:0]     lap_buf_q, lap_buf_d;
  bcd_t                     disp_q, disp_d;
  logic [IDX_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]           lap_count_q, lap_count_d;
  logic [IDX_W-1:0]         view_idx_q, view_idx_d;
  logic                     viewing_q, viewing_d;
  logic [HOLD_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic                     holding_q, holding_d;
  logic                     running_q, running_d;
  logic                     overflow_q, overflow_d;

  logic [NUM_DIGITS:0]      carry;
  logic [IDX_W-1:0]         rd_idx, last_idx;
  logic                     start_go, lap_go, view_go;
  logic                     do_clear, do_store, do_view, do_unview;

  // Ripple-carry BCD chain; digits 3 and 5 are tens of seconds/minutes (radix 6).
  assign carry[0] = tick && (state_q == S_RUN);
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    localparam int unsigned R = (i == 3 || i == 5) ? 6 : 10;
    msw_bcd_digit #(.RADIX(R)) u_dig (
      .d   (time_q[i]),
      .cin (carry[i]),
      .q   (time_inc[i]),
      .cout(carry[i+1])
    );
  end

  // Start beats lap beats view; only the winning pulse acts.
  assign start_go = btn_start;
  assign lap_go   = btn_lap & ~btn_start;
  assign view_go  = btn_view & ~btn_start & ~btn_lap;

  // Newest lap lives just below the write pointer; recall walks backwards from it.
  assign last_idx = wr_ptr_q - IDX_ONE;
  assign rd_idx   = wr_ptr_q - IDX_ONE - view_idx_q;

  always_comb begin
    state_d   = state_q;
    do_clear  = 1'b0;
    do_store  = 1'b0;
    do_view   = 1'b0;
    do_unview = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          state_d   = S_RUN;
          do_unview = 1'b1;
        end else if (lap_go) begin
          do_clear = 1'b1;
        end else if (view_go) begin
          do_view = 1'b1;
        end
      end
      S_RUN: begin
        if (start_go)    state_d  = S_PAUSE;
        else if (lap_go) do_store = 1'b1;
      end
      S_PAUSE: begin
        if (start_go) begin
          state_d   = S_RUN;
          do_unview = 1'b1;
        end else if (lap_go) begin
          state_d  = S_IDLE;
          do_clear = 1'b1;
        end else if (view_go) begin
          do_view = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    time_d      = time_inc;
    lap_buf_d   = lap_buf_q;
    wr_ptr_d    = wr_ptr_q;
    lap_count_d = lap_count_q;
    view_idx_d  = view_idx_q;
    viewing_d   = viewing_q;
    hold_cnt_d  = hold_cnt_q;
    overflow_d  = overflow_q | carry[NUM_DIGITS];

    if (tick && hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HOLD_ONE;

    if (do_store) begin
      // Store the pre-increment time even if a tick lands in the same cycle.
      lap_buf_d[wr_ptr_q] = time_q;
      wr_ptr_d            = wr_ptr_q + IDX_ONE;
      if (lap_count_q != CNT_MAX) lap_count_d = lap_count_q + CNT_ONE;
      hold_cnt_d          = HOLD_LOAD;
    end

    if (do_unview) begin
      viewing_d  = 1'b0;
      view_idx_d = '0;
    end

    if (do_view && lap_count_q != '0) begin
      if (!viewing_q) begin
        viewing_d  = 1'b1;
        view_idx_d = '0;
      end else if ({1'b0, view_idx_q} == lap_count_q - CNT_ONE) begin
        viewing_d  = 1'b0;
        view_idx_d = '0;
      end else begin
        view_idx_d = view_idx_q + IDX_ONE;
      end
    end

    if (do_clear) begin
      time_d      = '0;
      lap_buf_d   = '0;
      wr_ptr_d    = '0;
      lap_count_d = '0;
      view_idx_d  = '0;
      viewing_d   = 1'b0;
      hold_cnt_d  = '0;
      overflow_d  = 1'b0;
    end

    holding_d = (hold_cnt_d != '0);
    running_d = (state_d == S_RUN);

    // Display follows the registered state, so it lags a state change by one cycle.
    if (viewing_q)      disp_d = lap_buf_q[rd_idx];
    else if (holding_q) disp_d = lap_buf_q[last_idx];
    else                disp_d = time_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      time_q      <= '0;
      lap_buf_q   <= '0;
      disp_q      <= '0;
      wr_ptr_q    <= '0;
      lap_count_q <= '0;
      view_idx_q  <= '0;
      viewing_q   <= 1'b0;
      hold_cnt_q  <= '0;
      holding_q   <= 1'b0;
      running_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      lap_buf_q   <= lap_buf_d;
      disp_q      <= disp_d;
      wr_ptr_q    <= wr_ptr_d;
      lap_count_q <= lap_count_d;
      view_idx_q  <= view_idx_d;
      viewing_q   <= viewing_d;
      hold_cnt_q  <= hold_cnt_d;
      holding_q   <= holding_d;
      running_q   <= running_d;
      overflow_q  <= overflow_d;
    end
  end

  assign disp_bcd  = disp_q;
  assign lap_count = lap_count_q;
  assign view_idx  = view_idx_q;
  assign viewing   = viewing_q;
  assign holding   = holding_q;
  assign running   = running_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_multi_lap_stopwatch.sv
// Bench for multi_lap_stopwatch (default parameters: 4 digits, 4 laps, 200-tick hold).
// Stimulus pushes expected snapshots into a queue and raises chk_req; a monitor on
// the falling edge pops and compares them against the DUT outputs.
module tb_multi_lap_stopwatch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0, btn_start = 1'b0, btn_lap = 1'b0, btn_view = 1'b0;
  logic [15:0] disp_bcd;
  logic [2:0]  lap_count;
  logic [1:0]  view_idx;
  logic        viewing, holding, running, overflow;

  typedef struct packed {
    logic [15:0] disp;
    logic [2:0]  lc;
    logic [1:0]  vi;
    logic        vw, hd, rn, of;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  chk_req = 1'b0;
  int    checks = 0;
  int    errors = 0;

  multi_lap_stopwatch dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_view(btn_view),
    .disp_bcd(disp_bcd), .lap_count(lap_count), .view_idx(view_idx),
    .viewing(viewing), .holding(holding), .running(running), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Monitor: compares one queued snapshot per requested sample.
  always @(negedge clk) begin
    if (chk_req) begin
      exp_t  e;
      string nm;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: sample requested with no expectation queued");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (disp_bcd !== e.disp || lap_count !== e.lc || view_idx !== e.vi ||
            viewing !== e.vw || holding !== e.hd || running !== e.rn || overflow !== e.of) begin
          errors++;
          $display("FAIL %s: got disp=%h lc=%0d vi=%0d vw=%b hd=%b rn=%b of=%b, want disp=%h lc=%0d vi=%0d vw=%b hd=%b rn=%b of=%b",
                   nm, disp_bcd, lap_count, view_idx, viewing, holding, running, overflow,
                   e.disp, e.lc, e.vi, e.vw, e.hd, e.rn, e.of);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input bit s, input bit l, input bit v, input bit t);
    btn_start = s; btn_lap = l; btn_view = v; tick = t;
    cyc(1);
    btn_start = 0; btn_lap = 0; btn_view = 0; tick = 0;
  endtask

  task automatic ticks(input int n);
    tick = 1; cyc(n); tick = 0;
  endtask

  task automatic push_exp(input string nm, input logic [15:0] d, input int lc, input int vi,
                          input bit vw, input bit hd, input bit rn, input bit of);
    exp_t e;
    e.disp = d; e.lc = 3'(lc); e.vi = 2'(vi);
    e.vw = vw; e.hd = hd; e.rn = rn; e.of = of;
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_req = 1;
    @(negedge clk); #1;
    chk_req = 0;
  endtask

  initial begin
    cyc(2);
    push_exp("reset", 16'h0000, 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    cyc(2);

    // 12.34 s of counting
    drive(1, 0, 0, 0);
    ticks(1234); cyc(1);
    push_exp("count_1234", 16'h1234, 0, 0, 0, 0, 1, 0);

    // start and lap together in RUN: pause only, nothing stored
    drive(1, 1, 0, 0); cyc(1);
    push_exp("start_lap_same", 16'h1234, 0, 0, 0, 0, 0, 0);

    // lap in PAUSE clears to IDLE
    drive(0, 1, 0, 0); cyc(1);
    push_exp("pause_clear", 16'h0000, 0, 0, 0, 0, 0, 0);

    // tick+lap at 00.09: 0009 stored, live becomes 0010
    drive(1, 0, 0, 0);
    ticks(9);
    drive(0, 1, 0, 1); cyc(1);
    push_exp("tick_lap_store", 16'h0009, 1, 0, 0, 1, 1, 0);

    // lap at 00.50 (live 0010 + 40) and the 200-tick hold
    ticks(40);
    drive(0, 1, 0, 0); cyc(1);
    push_exp("hold_start", 16'h0050, 2, 0, 0, 1, 1, 0);
    ticks(199); cyc(1);
    push_exp("hold_199", 16'h0050, 2, 0, 0, 1, 1, 0);
    ticks(1); cyc(1);
    push_exp("hold_end", 16'h0250, 2, 0, 0, 0, 1, 0);

    // pause and recall both laps, then fall back to live
    drive(1, 0, 0, 0); cyc(1);
    push_exp("pause_live", 16'h0250, 2, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0); cyc(1);
    push_exp("view_newest", 16'h0050, 2, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0); cyc(1);
    push_exp("view_older", 16'h0009, 2, 1, 1, 0, 0, 0);
    drive(0, 0, 1, 0); cyc(1);
    push_exp("view_exit", 16'h0250, 2, 0, 0, 0, 0, 0);

    // view press in RUN does nothing
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0); cyc(1);
    push_exp("view_in_run", 16'h0250, 2, 0, 0, 0, 1, 0);

    // five laps at 1..5 s into a 4-deep buffer
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      ticks(100);
      drive(0, 1, 0, 0);
    end
    cyc(1);
    push_exp("lap_saturate", 16'h0500, 4, 0, 0, 1, 1, 0);
    ticks(200);
    drive(1, 0, 0, 0); cyc(1);
    push_exp("lap5_pause", 16'h0700, 4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0); cyc(1);
      push_exp($sformatf("recall_%0d", i), 16'h0500 - 16'(i) * 16'h0100, 4, i, 1, 0, 0, 0);
    end
    drive(0, 0, 1, 0); cyc(1);
    push_exp("recall_exit", 16'h0700, 4, 0, 0, 0, 0, 0);

    // start while viewing leaves view and resumes
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0); cyc(1);
    push_exp("start_exits_view", 16'h0700, 4, 0, 0, 0, 1, 0);

    // wrap at 59.99
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    ticks(5999); cyc(1);
    push_exp("at_5999", 16'h5999, 0, 0, 0, 0, 1, 0);
    ticks(1); cyc(1);
    push_exp("wrap", 16'h0000, 0, 0, 0, 0, 1, 1);
    ticks(5); cyc(1);
    push_exp("ovf_sticky", 16'h0005, 0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0); cyc(1);
    push_exp("ovf_pause", 16'h0005, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 0); cyc(1);
    push_exp("view_no_laps", 16'h0005, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0); cyc(1);
    push_exp("ovf_clear", 16'h0000, 0, 0, 0, 0, 0, 0);

    // asynchronous reset in the middle of a run
    drive(1, 0, 0, 0);
    tick = 1;
    cyc(30);
    #2 rst_n = 0;
    push_exp("async_reset", 16'h0000, 0, 0, 0, 0, 0, 0);
    tick = 0;
    cyc(2);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d expectations not compared, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
